conv_pool: RTL

Downstream stage of the 3x3 convolution engine: consumes its packed 32-bit output stream (32x32 pixels, 16 int8 channels per pixel, 4 words per pixel) and performs 2x2 stride-2 max-pooling with optional ReLU. It produces a 16x16x16 stream in the same packing. It has no backpressure; it must accept one word per cycle indefinitely.

---
 rtl/conv_pool.sv | 139 +++++++++++++
 1 files changed

// File: rtl/conv_pool.sv
// 2x2 stride-2 max-pool with optional ReLU over a packed int8 pixel stream.
// Even rows fill a half-width line buffer; odd rows pool against it and emit one word per group.
module conv_pool #(
    parameter int COLS   = 32,
    parameter int ROWS   = 32,
    parameter int GROUPS = 4,
    parameter int RELU   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_done
);

    // Minimum sizes: COLS >= 4, ROWS >= 2, GROUPS >= 2.
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int GW = $clog2(GROUPS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [31:0]     h_q  [GROUPS];
    logic [31:0]     lb_q [COLS/2][GROUPS];
    logic [31:0]     o_data_q, o_data_d;
    logic            o_valid_q, o_valid_d;
    logic            o_done_q, o_done_d;

    logic            acc, last_word;
    logic [31:0]     m, r, r_out, lb_rd;

    function automatic logic [31:0] bmax(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < 4; k++)
            res[8*k +: 8] = ($signed(a[8*k +: 8]) > $signed(b[8*k +: 8])) ? a[8*k +: 8] : b[8*k +: 8];
        return res;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
        logic [31:0] res;
        res = x;
        for (int k = 0; k < 4; k++)
            if (x[8*k+7]) res[8*k +: 8] = 8'h00;
        return res;
    endfunction

    // start overrides any word presented in the same cycle
    assign acc       = (state_q == RUN) && i_valid && !start;
    assign last_word = (row_q == RW'(ROWS-1)) && (col_q == CW'(COLS-1)) && (g_q == GW'(GROUPS-1));
    assign lb_rd     = lb_q[col_q[CW-1:1]][g_q];
    assign m         = bmax(h_q[g_q], i_data);
    assign r         = bmax(lb_rd, m);
    assign r_out     = (RELU != 0) ? relu(r) : r;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        col_d   = col_q;
        row_d   = row_q;
        if (start) begin
            state_d = RUN;
            g_d     = '0;
            col_d   = '0;
            row_d   = '0;
        end else if (acc) begin
            if (g_q == GW'(GROUPS-1)) begin
                g_d = '0;
                if (col_q == CW'(COLS-1)) begin
                    col_d = '0;
                    if (row_q == RW'(ROWS-1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                g_d = g_q + GW'(1);
            end
        end
    end

    always_comb begin
        o_valid_d = acc && col_q[0] && row_q[0];
        o_data_d  = o_valid_d ? r_out : '0;
        o_done_d  = o_valid_d && last_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            g_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            col_q     <= col_d;
            row_q     <= row_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_done_q  <= o_done_d;
        end
    end

    // Pixel hold (even col) and line buffer (even row, odd col) storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GROUPS; g++) begin
                h_q[g] <= '0;
                for (int c = 0; c < COLS/2; c++)
                    lb_q[c][g] <= '0;
            end
        end else if (acc) begin
            if (!col_q[0])
                h_q[g_q] <= i_data;
            else if (!row_q[0])
                lb_q[col_q[CW-1:1]][g_q] <= m;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_done  = o_done_q;

endmodule
